reg_write_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit enable-gated register bank between NREQ requesters. The register bank is built from master-slave D flip-flops with an En input. The arbiter grants one requester at a time and drives the bank's D and En for exactly one cycle. It then reads the bank back, checks that the value stored correctly, and returns a done/err handshake to the granted requester. It sits between the requester blocks and the shared register bank in the lab datapath.

---
 rtl/reg_arb_pkg.sv | 19 +
 rtl/reg_write_arbiter_rr_pick.sv | 28 ++
 rtl/reg_write_arbiter.sv | 97 +++++++++
 tb/tb_reg_write_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_arb_pkg;

   // Arbiter sequence: pick a winner, pulse En, read back, report.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   // Round-robin pointer width; a single requester still needs one bit.
   function automatic int ptr_width(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Round-robin selector: first set req bit at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; vld simply reflects whether any request is present.
module reg_write_arbiter_rr_pick
   import reg_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int PW   = ptr_width(NREQ)
)(
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [PW-1:0]   win,
   output logic            vld
);

   // Scan offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin : pick
      int idx;
      idx = 0;
      win = '0;
      vld = |req;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         if (req[idx]) win = PW'(idx);
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that writes one requester's data into a shared register bank and verifies it.
// Latency: request sampled at edge 0, En in cycle 1, readback in cycle 2, done/err in cycle 3; 4-cycle minimum period.
// Backpressure: requesters hold req/wdata until done; losers wait in IDLE until the pointer reaches them.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int NREQ  = 2
)(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] wdata,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic                  err,
   output logic [WIDTH-1:0]      reg_d,
   output logic                  reg_en,
   input  logic [WIDTH-1:0]      reg_q,
   output logic                  busy
);

   localparam int PW = ptr_width(NREQ);

   arb_state_t       state;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    win;
   logic [PW-1:0]    win_q;
   logic             win_vld;
   logic [WIDTH-1:0] win_data;
   logic [PW-1:0]    ptr_next;

   reg_write_arbiter_rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req  (req),
      .ptr  (ptr),
      .win  (win),
      .vld  (win_vld)
   );

   assign win_data = wdata[int'(win)*WIDTH +: WIDTH];
   assign ptr_next = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
   assign busy     = (state != IDLE);

   // Sequencer; reg_d doubles as the latched write data and reg_en comes straight from a flop.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         ptr    <= '0;
         win_q  <= '0;
         gnt    <= '0;
         done   <= '0;
         err    <= 1'b0;
         reg_d  <= '0;
         reg_en <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  state  <= WRITE;
                  win_q  <= win;
                  gnt    <= NREQ'(1) << win;
                  reg_d  <= win_data;
                  reg_en <= 1'b1;
               end
            end
            WRITE: begin
               state  <= CHECK;
               reg_en <= 1'b0;
            end
            CHECK: begin
               // The bank's slave stage captured on the falling edge of WRITE, so reg_q is settled here.
               state <= DONE;
               err   <= (reg_q != reg_d);
               gnt   <= '0;
               done  <= NREQ'(1) << win_q;
               ptr   <= ptr_next;
            end
            DONE: begin
               state <= IDLE;
               done  <= '0;
               err   <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               gnt    <= '0;
               done   <= '0;
               err    <= 1'b0;
               reg_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural master-slave register bank.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: requesters follow the hold-until-done protocol.
module tb_reg_write_arbiter;

   localparam int W = 4;
   localparam int N = 2;

   logic           CLK;
   logic           RST;
   logic [N-1:0]   req;
   logic [N*W-1:0] wdata;
   logic [N-1:0]   gnt;
   logic [N-1:0]   done;
   logic           err;
   logic [W-1:0]   reg_d;
   logic           reg_en;
   logic [W-1:0]   reg_q;
   logic           busy;

   logic [W-1:0]   bank;
   logic           stuck;
   int             n_tests;
   int             n_fail;

   reg_write_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .req    (req),
      .wdata  (wdata),
      .gnt    (gnt),
      .done   (done),
      .err    (err),
      .reg_d  (reg_d),
      .reg_en (reg_en),
      .reg_q  (reg_q),
      .busy   (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Master loads while CLK is high, slave captures on the falling edge.
   always @(negedge CLK) if (reg_en) bank <= reg_d;
   assign reg_q = stuck ? '0 : bank;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset_state();
      n_tests++;
      if ({gnt, done, err, reg_en, reg_d, busy} !== {2'b00, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: got gnt=%b done=%b err=%b en=%b d=%h busy=%b, want all zero",
                  gnt, done, err, reg_en, reg_d, busy);
      end
   endtask

   task automatic test_reset_mid_write();
      req = 2'b01; wdata = 8'h0C;
      tick();
      n_tests++;
      if (reg_en !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre_en: got %b want 1", reg_en);
      end
      #2 RST = 1'b1;
      #1;
      n_tests++;
      if ({gnt, reg_en, reg_d, busy, done, err} !== {2'b00, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0}) begin
         n_fail++;
         $display("FAIL rst_async: got gnt=%b en=%b d=%h busy=%b done=%b err=%b want zeros",
                  gnt, reg_en, reg_d, busy, done, err);
      end
      req = 2'b00;
      tick();
      RST = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_tests++;
         if ({done, busy} !== 3'b000) begin
            n_fail++; $display("FAIL rst_no_done c%0d: got done=%b busy=%b want 00/0", c, done, busy);
         end
      end
   endtask

   task automatic test_single_write();
      req = 2'b01; wdata = 8'h0A;
      tick();
      n_tests++;
      if ({gnt, reg_en, reg_d, done} !== {2'b01, 1'b1, 4'hA, 2'b00}) begin
         n_fail++; $display("FAIL single_c1: got gnt=%b en=%b d=%h done=%b want 01/1/a/00", gnt, reg_en, reg_d, done);
      end
      tick();
      n_tests++;
      if ({gnt, reg_en, reg_q, busy} !== {2'b01, 1'b0, 4'hA, 1'b1}) begin
         n_fail++; $display("FAIL single_c2: got gnt=%b en=%b q=%h busy=%b want 01/0/a/1", gnt, reg_en, reg_q, busy);
      end
      tick();
      n_tests++;
      if ({done, err, gnt, reg_en} !== {2'b01, 1'b0, 2'b00, 1'b0}) begin
         n_fail++; $display("FAIL single_c3: got done=%b err=%b gnt=%b en=%b want 01/0/00/0", done, err, gnt, reg_en);
      end
      tick();
      n_tests++;
      if ({done, busy} !== 3'b000) begin
         n_fail++; $display("FAIL single_c4: got done=%b busy=%b want 00/0", done, busy);
      end
      req = 2'b00;
   endtask

   task automatic test_contention();
      logic [N-1:0] oh;
      logic [W-1:0] dat;
      RST = 1'b1; tick(); RST = 1'b0;
      req = 2'b11; wdata = 8'h53;
      for (int g = 0; g < 4; g++) begin
         oh  = (g % 2 == 0) ? 2'b01 : 2'b10;
         dat = (g % 2 == 0) ? 4'h3 : 4'h5;
         for (int ph = 0; ph < 4; ph++) begin
            tick();
            n_tests++;
            if ({gnt, done, reg_en} !== {(ph < 2) ? oh : 2'b00, (ph == 2) ? oh : 2'b00, ph == 0}) begin
               n_fail++;
               $display("FAIL contend g%0d p%0d: got gnt=%b done=%b en=%b want gnt=%b done=%b en=%b",
                        g, ph, gnt, done, reg_en, (ph < 2) ? oh : 2'b00, (ph == 2) ? oh : 2'b00, ph == 0);
            end
            if (ph == 1) begin
               n_tests++;
               if (reg_q !== dat) begin
                  n_fail++; $display("FAIL contend_q g%0d: got %h want %h", g, reg_q, dat);
               end
            end
         end
      end
      req = 2'b00;
   endtask

   task automatic test_readback_fault();
      stuck = 1'b1;
      req = 2'b01; wdata = 8'h0F;
      tick(); tick(); tick();
      n_tests++;
      if ({done, err} !== {2'b01, 1'b1}) begin
         n_fail++; $display("FAIL fault_err: got done=%b err=%b want 01/1", done, err);
      end
      tick();
      n_tests++;
      if ({done, err} !== 3'b000) begin
         n_fail++; $display("FAIL fault_clear: got done=%b err=%b want 00/0", done, err);
      end
      req = 2'b00; stuck = 1'b0;
      tick();
      req = 2'b01; wdata = 8'h06;
      tick(); tick(); tick();
      n_tests++;
      if ({done, err} !== {2'b01, 1'b0}) begin
         n_fail++; $display("FAIL fault_recover: got done=%b err=%b want 01/0", done, err);
      end
      tick();
      req = 2'b00;
   endtask

   task automatic test_late_drop();
      req = 2'b10; wdata = 8'h90;
      tick();
      n_tests++;
      if (gnt !== 2'b10) begin
         n_fail++; $display("FAIL late_gnt: got %b want 10", gnt);
      end
      tick();
      n_tests++;
      if ({gnt, reg_q} !== {2'b10, 4'h9}) begin
         n_fail++; $display("FAIL late_check: got gnt=%b q=%h want 10/9", gnt, reg_q);
      end
      req = 2'b00;
      tick();
      n_tests++;
      if ({done, err} !== {2'b10, 1'b0}) begin
         n_fail++; $display("FAIL late_done: got done=%b err=%b want 10/0", done, err);
      end
      tick();
      req = 2'b11; wdata = 8'h12;
      tick();
      n_tests++;
      if (gnt !== 2'b01) begin
         n_fail++; $display("FAIL late_ptr: got gnt=%b want 01", gnt);
      end
      tick(); tick(); tick();
      req = 2'b00;
   endtask

   task automatic test_idle();
      req = 2'b00;
      for (int c = 0; c < 20; c++) begin
         tick();
         n_tests++;
         if ({busy, reg_en, gnt} !== 4'b0000) begin
            n_fail++; $display("FAIL idle c%0d: got busy=%b en=%b gnt=%b want 0/0/00", c, busy, reg_en, gnt);
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      bank    = '0;
      stuck   = 1'b0;
      req     = '0;
      wdata   = '0;
      RST     = 1'b1;
      #2;
      test_reset_state();
      tick();
      RST = 1'b0;
      tick();
      test_reset_mid_write();
      test_single_write();
      test_contention();
      test_readback_fault();
      test_late_drop();
      test_idle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
